// File: rtl/dmem_ctrl.sv
// Minisys data-memory controller: sized byte-lane RAM with sub-word access,
// misalignment rejection, power-up zero-fill and a UART program-load port.
module dmem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic                  unsigned_load,
  input  logic [31:0]           address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  read_valid,
  output logic                  misaligned,
  output logic                  busy,
  input  logic                  upg_active_i,
  input  logic                  upg_wen_i,
  input  logic [ADDR_WIDTH-1:0] upg_adr_i,
  input  logic [31:0]           upg_dat_i,
  input  logic                  upg_done_i
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_LOAD,
    S_RUN
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [31:0]           mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  misalign;
  logic                  run;
  logic [3:0]            cpu_be;
  logic [31:0]           cpu_wdata;
  logic [3:0]            wr_be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           load_val;
  logic                  unused_addr;

  // Upper address bits alias modulo the depth.
  assign word_idx    = address[ADDR_WIDTH+1:2];
  assign unused_addr = ^address[31:ADDR_WIDTH+2];
  assign run         = (state == S_RUN);
  assign busy        = (state != S_RUN);
  assign misalign    = ((size == 2'b01) && address[0]) ||
                       (size[1] && (address[1:0] != 2'b00));

  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR: if (clr_cnt == '1) state_next = upg_active_i ? S_LOAD : S_RUN;
      S_LOAD:  if (upg_done_i) state_next = S_RUN;
      S_RUN:   if (upg_active_i && !upg_done_i) state_next = S_LOAD;
      default: state_next = S_RUN;
    endcase
  end

  always_comb begin
    cpu_be    = 4'b1111;
    cpu_wdata = write_data;
    case (size)
      2'b00: begin
        cpu_be    = 4'b0001 << address[1:0];
        cpu_wdata = {4{write_data[7:0]}};
      end
      2'b01: begin
        cpu_be    = address[1] ? 4'b1100 : 4'b0011;
        cpu_wdata = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Single write port shared by the clear sweep, the uploader and the CPU.
  always_comb begin
    wr_be   = '0;
    wr_addr = word_idx;
    wr_data = cpu_wdata;
    case (state)
      S_CLEAR: begin
        wr_be   = '1;
        wr_addr = clr_cnt;
        wr_data = '0;
      end
      S_LOAD: begin
        if (upg_wen_i) begin
          wr_be   = '1;
          wr_addr = upg_adr_i;
          wr_data = upg_dat_i;
        end
      end
      default: begin
        if (mem_write && !misalign) wr_be = cpu_be;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Read sees the pre-edge contents, so a same-cycle store returns old data.
  assign rd_word = mem[word_idx];
  assign rd_half = address[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (address[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  always_comb begin
    case (size)
      2'b00:   load_val = {{24{~unsigned_load & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{~unsigned_load & rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;
      clr_cnt    <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_next;
      if (state == S_CLEAR) clr_cnt <= clr_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      read_valid <= run && mem_read && !misalign;
      misaligned <= run && (mem_read || mem_write) && misalign;
      if (run && mem_read && !misalign) read_data <= load_val;
    end
  end

endmodule
